// File: rtl/spi_flash_ctrl_pkg.sv
// Shared constants for the push-button SPI flash reader: opcodes and FSM state encodings.
package spi_flash_ctrl_pkg;

    localparam logic [7:0] OPC_WAKE = 8'hAB;
    localparam logic [7:0] OPC_READ = 8'h03;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_WAKE = 3'd1;
    localparam state_t ST_GAP  = 3'd2;
    localparam state_t ST_CMD  = 3'd3;
    localparam state_t ST_DATA = 3'd4;
    localparam state_t ST_DONE = 3'd5;

endpackage

// File: rtl/spi_flash_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle pulse on each accepted press.
module spi_flash_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_press
);

    localparam logic [6:0] CNT_LAST = 7'(DEBOUNCE_CYCLES - 1);

    logic       sync_q1;
    logic       sync_q2;
    logic       level;
    logic [6:0] cnt;

    // The counter only runs while the synchronised input disagrees with the accepted level,
    // so any glitch shorter than DEBOUNCE_CYCLES samples restarts it from zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
            o_press <= 1'b0;
        end else begin
            sync_q1 <= i_btn_n;
            sync_q2 <= sync_q1;
            o_press <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level   <= sync_q2;
                cnt     <= '0;
                o_press <= ~sync_q2;
            end else begin
                cnt <= cnt + 7'd1;
            end
        end
    end

endmodule

// File: rtl/spi_flash_ctrl.sv
// Push-button SPI NOR reader: wakes the flash (0xAB), then streams READ_LEN bytes from READ_ADDR (0x03).
module spi_flash_ctrl
    import spi_flash_ctrl_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          SCK_DIV         = 1,
    parameter logic [23:0] READ_ADDR       = 24'h000000,
    parameter int          READ_LEN        = 4,
    parameter int          CS_GAP_CYCLES   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn,
    output logic       o_spi_cs_n,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_busy,
    output state_t     o_dbg_state
);

    localparam int                 DIV_W     = $clog2(SCK_DIV) + 1;
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam int                 GAP_W     = $clog2(CS_GAP_CYCLES) + 1;
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(CS_GAP_CYCLES - 1);
    localparam logic [8:0]         LAST_BYTE = 9'(READ_LEN - 1);

    state_t             state;
    logic               press;
    logic               lead;
    logic [31:0]        tx;
    logic [6:0]         rx;
    logic [5:0]         bit_cnt;
    logic [8:0]         byte_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               half_done;
    logic [7:0]         rx_next;

    spi_flash_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn_n(i_btn),
        .o_press(press)
    );

    assign half_done   = (div_cnt == DIV_LAST);
    assign rx_next     = {rx, i_spi_miso};
    assign o_dbg_state = state;

    // o_data_valid is a one-cycle strobe with no back-pressure: the consumer must take o_data
    // on the cycle the strobe is high, the next byte overwrites it regardless.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            o_spi_cs_n   <= 1'b1;
            o_spi_clk    <= 1'b0;
            o_spi_mosi   <= 1'b0;
            o_data       <= 8'h00;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            lead         <= 1'b0;
            tx           <= '0;
            rx           <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
        end else begin
            o_data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_spi_cs_n <= 1'b1;
                    o_spi_clk  <= 1'b0;
                    o_spi_mosi <= 1'b0;
                    if (press) begin
                        state      <= ST_WAKE;
                        o_busy     <= 1'b1;
                        o_spi_cs_n <= 1'b0;
                        lead       <= 1'b1;
                        tx         <= {OPC_WAKE, 24'h000000};
                        bit_cnt    <= '0;
                        div_cnt    <= '0;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state      <= ST_CMD;
                        o_spi_cs_n <= 1'b0;
                        lead       <= 1'b1;
                        tx         <= {OPC_READ, READ_ADDR};
                        bit_cnt    <= '0;
                        div_cnt    <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                // Lead cycle: CS_n already low, first bit goes onto MOSI for the coming low half.
                ST_WAKE, ST_CMD, ST_DATA: begin
                    if (lead) begin
                        lead       <= 1'b0;
                        o_spi_mosi <= tx[31];
                        tx         <= {tx[30:0], 1'b0};
                    end else if (!half_done) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else if (!o_spi_clk) begin
                        div_cnt   <= '0;
                        o_spi_clk <= 1'b1;
                    end else begin
                        // End of the high half: sample MISO, drop SCK, present the next MOSI bit.
                        div_cnt    <= '0;
                        o_spi_clk  <= 1'b0;
                        rx         <= rx_next[6:0];
                        bit_cnt    <= bit_cnt + 6'd1;
                        o_spi_mosi <= tx[31];
                        tx         <= {tx[30:0], 1'b0};
                        case (state)
                            ST_WAKE: begin
                                if (bit_cnt == 6'd7) begin
                                    state      <= ST_GAP;
                                    o_spi_cs_n <= 1'b1;
                                    o_spi_mosi <= 1'b0;
                                    gap_cnt    <= '0;
                                end
                            end
                            ST_CMD: begin
                                if (bit_cnt == 6'd31) begin
                                    state      <= ST_DATA;
                                    o_spi_mosi <= 1'b0;
                                    bit_cnt    <= '0;
                                    byte_cnt   <= '0;
                                end
                            end
                            default: begin
                                o_spi_mosi <= 1'b0;
                                if (bit_cnt == 6'd7) begin
                                    bit_cnt      <= '0;
                                    o_data       <= rx_next;
                                    o_data_valid <= 1'b1;
                                    if (byte_cnt == LAST_BYTE) begin
                                        state      <= ST_DONE;
                                        o_spi_cs_n <= 1'b1;
                                    end else begin
                                        byte_cnt <= byte_cnt + 9'd1;
                                    end
                                end
                            end
                        endcase
                    end
                end

                ST_DONE: begin
                    o_spi_cs_n <= 1'b1;
                    o_spi_clk  <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: begin
                    state      <= ST_IDLE;
                    o_spi_cs_n <= 1'b1;
                    o_spi_clk  <= 1'b0;
                    o_spi_mosi <= 1'b0;
                    o_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed bench for spi_flash_ctrl: behavioural SPI flash, bus monitor and per-scenario checks.
`timescale 1ns/100ps
module tb_spi_flash_ctrl;
    import spi_flash_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic btn  = 1'b1;
    logic btn3 = 1'b1;
    logic sel3 = 1'b0;
    always #62.5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic       cs_n, sck, mosi, valid, busy;
    logic [7:0] data;
    state_t     dbg;
    logic       cs3_n, sck3, mosi3, valid3, busy3;
    logic [7:0] data3;
    state_t     dbg3;
    logic       miso = 1'b0;

    spi_flash_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_spi_cs_n(cs_n), .o_spi_clk(sck), .o_spi_mosi(mosi), .i_spi_miso(miso),
        .o_data(data), .o_data_valid(valid), .o_busy(busy), .o_dbg_state(dbg)
    );

    spi_flash_ctrl #(.SCK_DIV(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_btn(btn3),
        .o_spi_cs_n(cs3_n), .o_spi_clk(sck3), .o_spi_mosi(mosi3), .i_spi_miso(miso),
        .o_data(data3), .o_data_valid(valid3), .o_busy(busy3), .o_dbg_state(dbg3)
    );

    logic       m_cs, m_sck, m_mosi, m_valid, m_busy;
    logic [7:0] m_data;
    assign m_cs    = sel3 ? cs3_n  : cs_n;
    assign m_sck   = sel3 ? sck3   : sck;
    assign m_mosi  = sel3 ? mosi3  : mosi;
    assign m_valid = sel3 ? valid3 : valid;
    assign m_busy  = sel3 ? busy3  : busy;
    assign m_data  = sel3 ? data3  : data;

    // ---------------- flash model (mode 0) ----------------
    logic [7:0]  mem [0:7] = '{8'h9F, 8'h3C, 8'hA5, 8'h61, 8'hD2, 8'h07, 8'h88, 8'h5E};
    logic [7:0]  exp_data [0:3] = '{8'h9F, 8'h3C, 8'hA5, 8'h61};
    logic [7:0]  exp_mosi [0:8] = '{8'hAB, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [31:0] f_cmd = '0;
    int          f_bits = 0;
    int          f_outn = 0;
    logic        f_rd = 1'b0;
    logic [7:0]  f_sh = '0;
    logic [23:0] f_addr = '0;
    logic        p_cs = 1'b1;
    logic        p_sck = 1'b0;
    logic [7:0]  mosi_q[$];
    int          sess_q[$];

    always @(m_cs or m_sck) begin
        if (m_cs === 1'b1) begin
            if (p_cs !== 1'b1) sess_q.push_back(f_bits);
            f_bits = 0;
            f_rd   = 1'b0;
            miso   = 1'b0;
        end else if (m_cs === 1'b0) begin
            if (p_sck === 1'b0 && m_sck === 1'b1) begin
                f_cmd  = {f_cmd[30:0], m_mosi};
                f_bits = f_bits + 1;
                if (f_bits % 8 == 0) mosi_q.push_back(f_cmd[7:0]);
            end else if (p_sck === 1'b1 && m_sck === 1'b0) begin
                if (f_bits == 32 && f_cmd[31:24] == 8'h03) begin
                    f_rd   = 1'b1;
                    f_addr = f_cmd[23:0];
                    f_sh   = mem[f_addr[2:0]];
                    f_outn = 0;
                end
                if (f_rd) begin
                    if (f_outn == 8) begin
                        f_addr = f_addr + 24'd1;
                        f_sh   = mem[f_addr[2:0]];
                        f_outn = 0;
                    end
                    miso   = f_sh[7];
                    f_sh   = {f_sh[6:0], 1'b0};
                    f_outn = f_outn + 1;
                end
            end
        end
        p_cs  = m_cs;
        p_sck = m_sck;
    end

    // ---------------- bus monitor (samples on falling clk) ----------------
    logic [7:0] got_q[$];
    int         hi_q[$];
    int         gap_q[$];
    int         sck_cs_err = 0;
    int         cs_low_n = 0;
    int         hi_run = 0;
    int         cs_hi_run = 0;

    always @(negedge clk) begin
        if (m_valid === 1'b1) got_q.push_back(m_data);
        if (m_cs === 1'b1 && m_sck !== 1'b0) sck_cs_err = sck_cs_err + 1;
        if (m_sck === 1'b1) hi_run = hi_run + 1;
        else if (hi_run > 0) begin
            hi_q.push_back(hi_run);
            hi_run = 0;
        end
        if (m_cs === 1'b0) begin
            cs_low_n = cs_low_n + 1;
            if (cs_hi_run > 0) gap_q.push_back(cs_hi_run);
            cs_hi_run = 0;
        end else begin
            cs_hi_run = cs_hi_run + 1;
        end
    end

    // ---------------- driver tasks ----------------
    int b_got, b_mosi, b_sess, b_hi, b_gap, b_err, b_cslow;
    logic [7:0] exp_q[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic snapshot;
        b_got   = got_q.size();
        b_mosi  = mosi_q.size();
        b_sess  = sess_q.size();
        b_hi    = hi_q.size();
        b_gap   = gap_q.size();
        b_err   = sck_cs_err;
        b_cslow = cs_low_n;
    endtask

    task automatic wait_txn(input int budget, output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (m_busy === 1'b1) seen = 1'b1;
            else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #1 rst = 1'b1;
        #20;
        n_checks++; if (cs_n !== 1'b1)  begin n_fails++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
        n_checks++; if (sck !== 1'b0)   begin n_fails++; $display("FAIL rst_sck: got %b want 0", sck); end
        n_checks++; if (mosi !== 1'b0)  begin n_fails++; $display("FAIL rst_mosi: got %b want 0", mosi); end
        n_checks++; if (data !== 8'h00) begin n_fails++; $display("FAIL rst_data: got %h want 00", data); end
        n_checks++; if (valid !== 1'b0) begin n_fails++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_checks++; if (busy !== 1'b0)  begin n_fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (dbg !== ST_IDLE) begin n_fails++; $display("FAIL rst_state: got %0d want %0d", dbg, ST_IDLE); end
        n_checks++; if (cs3_n !== 1'b1) begin n_fails++; $display("FAIL rst_cs3_n: got %b want 1", cs3_n); end
        tick(3);
        @(negedge clk) rst = 1'b0;
        snapshot();
        tick(8000);
        #1;
        n_checks++; if (got_q.size() != b_got) begin n_fails++; $display("FAIL idle_valid: got %0d strobes want 0", got_q.size() - b_got); end
        n_checks++; if (cs_low_n != b_cslow)   begin n_fails++; $display("FAIL idle_cs: got %0d low samples want 0", cs_low_n - b_cslow); end
        n_checks++; if (hi_q.size() != b_hi)   begin n_fails++; $display("FAIL idle_sck: got %0d pulses want 0", hi_q.size() - b_hi); end
    endtask

    task automatic test_press;
        bit ok;
        int bad;
        snapshot();
        fork
            begin btn = 1'b0; #10000; btn = 1'b1; end
            wait_txn(4000, ok);
        join
        tick(4);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL press_timeout: got no end want busy fall"); end
        n_checks++; if (sess_q.size() - b_sess != 2) begin n_fails++; $display("FAIL press_sessions: got %0d want 2", sess_q.size() - b_sess); end
        else begin
            n_checks++; if (sess_q[b_sess] != 8)    begin n_fails++; $display("FAIL press_wake_bits: got %0d want 8", sess_q[b_sess]); end
            n_checks++; if (sess_q[b_sess+1] != 64) begin n_fails++; $display("FAIL press_read_bits: got %0d want 64", sess_q[b_sess+1]); end
        end
        n_checks++; if (mosi_q.size() - b_mosi != 9) begin n_fails++; $display("FAIL press_mosi_len: got %0d want 9", mosi_q.size() - b_mosi); end
        else for (int i = 0; i < 9; i++) begin
            n_checks++; if (mosi_q[b_mosi+i] !== exp_mosi[i]) begin n_fails++; $display("FAIL press_mosi[%0d]: got %h want %h", i, mosi_q[b_mosi+i], exp_mosi[i]); end
        end
        n_checks++; if (gap_q.size() - b_gap != 2) begin n_fails++; $display("FAIL press_gap_cnt: got %0d want 2", gap_q.size() - b_gap); end
        else begin
            n_checks++; if (gap_q[b_gap+1] != 8) begin n_fails++; $display("FAIL press_gap: got %0d want 8", gap_q[b_gap+1]); end
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_data[i]);
        n_checks++; if (got_q.size() - b_got != 4) begin n_fails++; $display("FAIL press_strobes: got %0d want 4", got_q.size() - b_got); end
        for (int i = b_got; i < got_q.size() && exp_q.size() > 0; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++; if (got_q[i] !== e) begin n_fails++; $display("FAIL press_data[%0d]: got %h want %h", i - b_got, got_q[i], e); end
        end
        exp_q.delete();
        bad = 0;
        for (int i = b_hi; i < hi_q.size(); i++) if (hi_q[i] != 1) bad++;
        n_checks++; if (bad != 0) begin n_fails++; $display("FAIL press_sck_high: got %0d bad pulses want 0", bad); end
        n_checks++; if (sck_cs_err != b_err) begin n_fails++; $display("FAIL press_sck_cs: got %0d samples want 0", sck_cs_err - b_err); end
        n_checks++; if (cs_n !== 1'b1) begin n_fails++; $display("FAIL press_end_cs: got %b want 1", cs_n); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL press_end_busy: got %b want 0", busy); end
        n_checks++; if (data !== 8'h61) begin n_fails++; $display("FAIL press_last_data: got %h want 61", data); end
    endtask

    task automatic test_bounce;
        bit ok;
        snapshot();
        fork
            begin
                for (int i = 0; i < 10; i++) begin btn = ~btn; tick(3); end
                btn = 1'b0;
            end
            wait_txn(4000, ok);
        join
        btn = 1'b1;
        tick(300);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL bounce_timeout: got no end want busy fall"); end
        n_checks++; if (sess_q.size() - b_sess != 2) begin n_fails++; $display("FAIL bounce_sessions: got %0d want 2", sess_q.size() - b_sess); end
        n_checks++; if (got_q.size() - b_got != 4) begin n_fails++; $display("FAIL bounce_strobes: got %0d want 4", got_q.size() - b_got); end
        else for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_q[b_got+i] !== exp_data[i]) begin n_fails++; $display("FAIL bounce_data[%0d]: got %h want %h", i, got_q[b_got+i], exp_data[i]); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        snapshot();
        fork
            begin btn = 1'b0; tick(30); btn = 1'b1; tick(30); btn = 1'b0; tick(30); btn = 1'b1; end
            wait_txn(4000, ok);
        join
        tick(200);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL b2b_timeout: got no end want busy fall"); end
        n_checks++; if (sess_q.size() - b_sess != 2) begin n_fails++; $display("FAIL b2b_dropped_sessions: got %0d want 2", sess_q.size() - b_sess); end
        n_checks++; if (got_q.size() - b_got != 4) begin n_fails++; $display("FAIL b2b_dropped_strobes: got %0d want 4", got_q.size() - b_got); end
        snapshot();
        fork
            begin btn = 1'b0; tick(30); btn = 1'b1; end
            wait_txn(4000, ok);
        join
        tick(4);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL b2b_second_timeout: got no end want busy fall"); end
        n_checks++; if (mosi_q.size() - b_mosi != 9) begin n_fails++; $display("FAIL b2b_mosi_len: got %0d want 9", mosi_q.size() - b_mosi); end
        else for (int i = 0; i < 9; i++) begin
            n_checks++; if (mosi_q[b_mosi+i] !== exp_mosi[i]) begin n_fails++; $display("FAIL b2b_mosi[%0d]: got %h want %h", i, mosi_q[b_mosi+i], exp_mosi[i]); end
        end
        n_checks++; if (got_q.size() - b_got != 4) begin n_fails++; $display("FAIL b2b_strobes: got %0d want 4", got_q.size() - b_got); end
        else for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_q[b_got+i] !== exp_data[i]) begin n_fails++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[b_got+i], exp_data[i]); end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        ok = 1'b0;
        btn = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (dbg === ST_DATA) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fails++; $display("FAIL mid_reach_data: got state %0d want %0d", dbg, ST_DATA); end
        tick(20);
        #20 rst = 1'b1;
        #1;
        n_checks++; if (cs_n !== 1'b1)   begin n_fails++; $display("FAIL mid_cs_n: got %b want 1", cs_n); end
        n_checks++; if (sck !== 1'b0)    begin n_fails++; $display("FAIL mid_sck: got %b want 0", sck); end
        n_checks++; if (busy !== 1'b0)   begin n_fails++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_checks++; if (data !== 8'h00)  begin n_fails++; $display("FAIL mid_data: got %h want 00", data); end
        n_checks++; if (dbg !== ST_IDLE) begin n_fails++; $display("FAIL mid_state: got %0d want %0d", dbg, ST_IDLE); end
        btn = 1'b1;
        tick(5);
        @(negedge clk) rst = 1'b0;
        tick(60);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL mid_no_resume: got busy %b want 0", busy); end
        snapshot();
        fork
            begin btn = 1'b0; tick(30); btn = 1'b1; end
            wait_txn(4000, ok);
        join
        tick(4);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL mid_restart_timeout: got no end want busy fall"); end
        n_checks++; if (mosi_q.size() == b_mosi || mosi_q[b_mosi] !== 8'hAB) begin
            n_fails++; $display("FAIL mid_restart_wake: got %0d new bytes want first AB", mosi_q.size() - b_mosi);
        end
        n_checks++; if (got_q.size() - b_got != 4) begin n_fails++; $display("FAIL mid_restart_strobes: got %0d want 4", got_q.size() - b_got); end
        else for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_q[b_got+i] !== exp_data[i]) begin n_fails++; $display("FAIL mid_restart_data[%0d]: got %h want %h", i, got_q[b_got+i], exp_data[i]); end
        end
    endtask

    task automatic test_div3;
        bit ok;
        int bad;
        sel3 = 1'b1;
        tick(2);
        snapshot();
        fork
            begin btn3 = 1'b0; #10000; btn3 = 1'b1; end
            wait_txn(6000, ok);
        join
        tick(4);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL div3_timeout: got no end want busy fall"); end
        bad = 0;
        for (int i = b_hi; i < hi_q.size(); i++) if (hi_q[i] != 3) bad++;
        n_checks++; if (hi_q.size() - b_hi != 72) begin n_fails++; $display("FAIL div3_pulses: got %0d want 72", hi_q.size() - b_hi); end
        n_checks++; if (bad != 0) begin n_fails++; $display("FAIL div3_sck_high: got %0d bad pulses want 0", bad); end
        n_checks++; if (gap_q.size() - b_gap != 2 || gap_q[b_gap+1] != 8) begin
            n_fails++; $display("FAIL div3_gap: got %0d runs want 2 with gap 8", gap_q.size() - b_gap);
        end
        n_checks++; if (mosi_q.size() - b_mosi != 9) begin n_fails++; $display("FAIL div3_mosi_len: got %0d want 9", mosi_q.size() - b_mosi); end
        else for (int i = 0; i < 9; i++) begin
            n_checks++; if (mosi_q[b_mosi+i] !== exp_mosi[i]) begin n_fails++; $display("FAIL div3_mosi[%0d]: got %h want %h", i, mosi_q[b_mosi+i], exp_mosi[i]); end
        end
        n_checks++; if (got_q.size() - b_got != 4) begin n_fails++; $display("FAIL div3_strobes: got %0d want 4", got_q.size() - b_got); end
        else for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_q[b_got+i] !== exp_data[i]) begin n_fails++; $display("FAIL div3_data[%0d]: got %h want %h", i, got_q[b_got+i], exp_data[i]); end
        end
        n_checks++; if (sck_cs_err != b_err) begin n_fails++; $display("FAIL div3_sck_cs: got %0d samples want 0", sck_cs_err - b_err); end
        sel3 = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_press();
        tick(50);
        test_bounce();
        tick(50);
        test_back_to_back();
        tick(50);
        test_reset_mid();
        tick(50);
        test_div3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got no end of test want finish before 20 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
